// File: rtl/fetch_ctrl.sv
// Fetch control: vector-table fetch for reset/exceptions/interrupt, EPC+cause save, eret return, double-fault restart.
// Latency: pc_load 1+W cycles after an event seen in NORMAL (W = memory wait cycles); eret loads in the same cycle.
// Backpressure: mem_req/mem_addr held stable until mem_ack; decode stalled through extend meanwhile.
module fetch_ctrl #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                N_EXPT   = 2,
  parameter logic [ADDR_W-1:0] TBL_BASE = '0,
  parameter int                CAUSE_W  = $clog2(N_EXPT+2)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_EXPT-1:0]  expt,
  input  logic               int_req,
  input  logic               eret,
  input  logic [ADDR_W-1:0]  pc,
  input  logic               mem_ack,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               pc_load,
  output logic [ADDR_W-1:0]  pc_next,
  output logic               extend,
  output logic [1:0]         fetch_src,
  output logic [ADDR_W-1:0]  epc,
  output logic [CAUSE_W-1:0] cause,
  output logic               in_handler
);

  typedef enum logic [1:0] {S_RESET, S_LOOKUP, S_NORMAL, S_VECTOR} state_t;

  state_t               state, state_nxt;
  logic [ADDR_W-1:0]    epc_nxt;
  logic [CAUSE_W-1:0]   cause_nxt;
  logic                 hnd_nxt;
  logic [CAUSE_W-1:0]   tbl_idx;
  logic [CAUSE_W-1:0]   expt_idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_RESET;
      epc        <= '0;
      cause      <= '0;
      in_handler <= 1'b0;
    end else begin
      state      <= state_nxt;
      epc        <= epc_nxt;
      cause      <= cause_nxt;
      in_handler <= hnd_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    epc_nxt   = epc;
    cause_nxt = cause;
    hnd_nxt   = in_handler;
    mem_req   = 1'b0;
    pc_load   = 1'b0;
    pc_next   = mem_rdata[ADDR_W-1:0];
    extend    = 1'b1;
    fetch_src = 2'b00;
    tbl_idx   = '0;

    // Downward scan so the lowest set source (highest priority) wins.
    expt_idx = '0;
    for (int i = N_EXPT-1; i >= 0; i--) begin
      if (expt[i]) expt_idx = CAUSE_W'(i+1);
    end

    case (state)
      S_RESET: state_nxt = S_LOOKUP;
      S_LOOKUP: begin
        mem_req   = 1'b1;
        fetch_src = 2'b01;
        if (mem_ack) begin
          pc_load   = 1'b1;
          state_nxt = S_NORMAL;
        end
      end
      S_NORMAL: begin
        extend = 1'b0;
        if (|expt && in_handler) begin
          state_nxt = S_LOOKUP;
        end else if (|expt) begin
          epc_nxt   = pc;
          cause_nxt = expt_idx;
          state_nxt = S_VECTOR;
        end else if (int_req && !in_handler) begin
          epc_nxt   = pc;
          cause_nxt = CAUSE_W'(N_EXPT+1);
          state_nxt = S_VECTOR;
        end else if (eret && in_handler) begin
          pc_load   = 1'b1;
          pc_next   = epc;
          fetch_src = 2'b10;
          hnd_nxt   = 1'b0;
        end
      end
      S_VECTOR: begin
        mem_req   = 1'b1;
        fetch_src = 2'b01;
        tbl_idx   = cause;
        if (mem_ack) begin
          pc_load   = 1'b1;
          hnd_nxt   = 1'b1;
          state_nxt = S_NORMAL;
        end
      end
      default: state_nxt = S_RESET;
    endcase

    mem_addr = TBL_BASE + (ADDR_W'(tbl_idx) << 2);
  end

endmodule
